// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the CORDIC request path.
// Angles are signed Q3.13 radians; x is signed Q3.13 magnitude.
package cordic_pkg;

    localparam int ANGLE_W = 16;
    localparam int FUNC_W  = 4;
    localparam int REQ_W   = FUNC_W + ANGLE_W + 1;

    localparam logic signed [ANGLE_W-1:0] PI             = 16'sh6488;
    localparam logic signed [ANGLE_W-1:0] PI_2           = 16'sh3244;
    localparam logic        [ANGLE_W-1:0] X_INIT_DEFAULT = 16'h2000;

    localparam logic [FUNC_W-1:0] FUNC_SIN   = 4'b0001;
    localparam logic [FUNC_W-1:0] FUNC_COS   = 4'b0010;
    localparam logic [FUNC_W-1:0] FUNC_TAN   = 4'b0100;
    localparam logic [FUNC_W-1:0] FUNC_ANGLE = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [FUNC_W-1:0]  func;
        logic [ANGLE_W-1:0] z0;
        logic               neg;
    } req_entry_t;

    function automatic logic is_onehot(input logic [FUNC_W-1:0] f);
        return (f != '0) && ((f & (f - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/cordic_req_fifo.sv
// Small synchronous FIFO for folded CORDIC requests. Head is visible
// combinationally; push and pop in the same cycle are legal when full or empty.
module cordic_req_fifo
    import cordic_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = REQ_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             bypass;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_COUNT);

    // On an empty FIFO a simultaneous push/pop passes the word straight through.
    assign bypass  = empty && push && pop;
    assign wr_en   = push && !bypass && (!full || pop);
    assign rd_en   = pop && !empty;
    assign rd_data = empty ? wr_data : mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/cordic_input_stage.sv
// Request front end for the CORDIC core: validates, quadrant-folds, buffers
// and launches operations one at a time. Folding is enabled by QUAD_FOLD_EN.
module cordic_input_stage
    import cordic_pkg::*;
#(
    parameter int                 DEPTH  = 2,
    parameter logic [ANGLE_W-1:0] X_INIT = X_INIT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [FUNC_W-1:0]  req_func,
    input  logic [ANGLE_W-1:0] req_angle,
    output logic               core_start,
    output logic [ANGLE_W-1:0] core_x0,
    output logic [ANGLE_W-1:0] core_y0,
    output logic [ANGLE_W-1:0] core_z0,
    output logic [FUNC_W-1:0]  core_func,
    output logic               core_neg,
    input  logic               core_done,
    output logic               busy,
    output logic               err_illegal
);

`ifdef QUAD_FOLD_EN
    localparam logic signed [ANGLE_W-1:0] RANGE_LIMIT = PI;
`else
    localparam logic signed [ANGLE_W-1:0] RANGE_LIMIT = PI_2;
`endif

    state_t             state_reg;
    state_t             state_next;
    logic               accept;
    logic               legal;
    logic               push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               load_outputs;
    logic signed [ANGLE_W-1:0] angle_s;
    logic [ANGLE_W-1:0] fold_z0;
    logic               fold_neg;
    req_entry_t         wr_entry;
    req_entry_t         head;
    logic [REQ_W-1:0]   head_bits;

    logic [ANGLE_W-1:0] x0_reg;
    logic [ANGLE_W-1:0] y0_reg;
    logic [ANGLE_W-1:0] z0_reg;
    logic [FUNC_W-1:0]  func_reg;
    logic               neg_reg;
    logic               err_reg;

    assign angle_s   = req_angle;
    assign req_ready = !fifo_full;
    assign accept    = req_valid && req_ready;
    assign legal     = is_onehot(req_func)
                    && (angle_s <= RANGE_LIMIT)
                    && (angle_s >= -RANGE_LIMIT);
    assign push      = accept && legal;

`ifdef QUAD_FOLD_EN
    // Angles beyond +/-pi/2 are rotated by pi; the core result is negated later.
    always_comb begin
        fold_z0  = req_angle;
        fold_neg = 1'b0;
        if (angle_s > PI_2) begin
            fold_z0  = angle_s - PI;
            fold_neg = 1'b1;
        end else if (angle_s < -PI_2) begin
            fold_z0  = angle_s + PI;
            fold_neg = 1'b1;
        end
    end
`else
    assign fold_z0  = req_angle;
    assign fold_neg = 1'b0;
`endif

    assign wr_entry = '{func: req_func, z0: fold_z0, neg: fold_neg};
    assign head     = req_entry_t'(head_bits);

    cordic_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (head_bits),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand registers load on entry to ISSUE so they are valid with core_start.
    always_comb begin
        state_next   = state_reg;
        fifo_pop     = 1'b0;
        load_outputs = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next   = ST_ISSUE;
                    load_outputs = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
                fifo_pop   = 1'b1;
            end
            ST_WAIT: begin
                if (core_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_reg   <= '0;
            y0_reg   <= '0;
            z0_reg   <= '0;
            func_reg <= '0;
            neg_reg  <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            err_reg <= accept && !legal;
            if (load_outputs) begin
                x0_reg   <= X_INIT;
                y0_reg   <= '0;
                z0_reg   <= head.z0;
                func_reg <= head.func;
                neg_reg  <= head.neg;
            end
        end
    end

    assign core_start  = (state_reg == ST_ISSUE);
    assign core_x0     = x0_reg;
    assign core_y0     = y0_reg;
    assign core_z0     = z0_reg;
    assign core_func   = func_reg;
    assign core_neg    = neg_reg;
    assign busy        = (state_reg != ST_IDLE) || !fifo_empty;
    assign err_illegal = err_reg;

endmodule

// File: tb/tb_cordic_input_stage.sv
// Directed bench for cordic_input_stage: reset, validation, folding,
// buffering order/backpressure and mid-operation reset.
module tb_cordic_input_stage;

`ifdef QUAD_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_func;
    logic [15:0] req_angle;
    logic        core_start;
    logic [15:0] core_x0;
    logic [15:0] core_y0;
    logic [15:0] core_z0;
    logic [3:0]  core_func;
    logic        core_neg;
    logic        core_done;
    logic        busy;
    logic        err_illegal;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] issued_z0 [64];
    int          n_issued = 0;

    cordic_input_stage #(
        .DEPTH  (2),
        .X_INIT (16'h2000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_func    (req_func),
        .req_angle   (req_angle),
        .core_start  (core_start),
        .core_x0     (core_x0),
        .core_y0     (core_y0),
        .core_z0     (core_z0),
        .core_func   (core_func),
        .core_neg    (core_neg),
        .core_done   (core_done),
        .busy        (busy),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_start) begin
            issued_z0[n_issued % 64] <= core_z0;
            n_issued <= n_issued + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
    endtask

    task automatic push_req(input logic [3:0] f, input logic [15:0] a);
        bit acc;
        int n;
        n = 0;
        req_valid = 1'b1;
        req_func  = f;
        req_angle = a;
        do begin
            acc = req_ready;
            step();
            n++;
        end while (!acc && n < 20);
        req_valid = 1'b0;
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic single(input string tag, input logic [3:0] f, input logic [15:0] a,
                          input logic exp_err, input logic [15:0] exp_z0, input logic exp_neg);
        int base;
        base = n_issued;
        req_valid = 1'b1;
        req_func  = f;
        req_angle = a;
        check({tag, "_ready"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        check({tag, "_err"}, err_illegal, exp_err);
        check({tag, "_start_n1"}, core_start, 0);
        if (exp_err) begin
            check({tag, "_busy_rej"}, busy, 0);
            step();
            check({tag, "_err_1cyc"}, err_illegal, 0);
            step();
            check({tag, "_no_start"}, n_issued - base, 0);
        end else begin
            step();
            check({tag, "_start_n2"}, core_start, 1);
            check({tag, "_z0"}, core_z0, exp_z0);
            check({tag, "_neg"}, core_neg, exp_neg);
            check({tag, "_func"}, core_func, f);
            check({tag, "_x0"}, core_x0, 16'h2000);
            check({tag, "_y0"}, core_y0, 16'h0000);
            step();
            check({tag, "_start_1cyc"}, core_start, 0);
            check({tag, "_busy_wait"}, busy, 1);
            check({tag, "_z0_hold"}, core_z0, exp_z0);
            pulse_done();
            check({tag, "_busy_done"}, busy, 0);
            check({tag, "_one_start"}, n_issued - base, 1);
        end
    endtask

    typedef struct {
        string       tag;
        logic [3:0]  f;
        logic [15:0] a;
        logic        err_f;
        logic [15:0] z_f;
        logic        neg_f;
        logic        err_nf;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{"sin_1000",  4'b0001, 16'h1000, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1]  = '{"cos_5000",  4'b0010, 16'h5000, 1'b0, 16'hEB78, 1'b1, 1'b1};
        vecs[2]  = '{"func_0011", 4'b0011, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[3]  = '{"ang_7000",  4'b0001, 16'h7000, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[4]  = '{"tan_pi2",   4'b0100, 16'h3244, 1'b0, 16'h3244, 1'b0, 1'b0};
        vecs[5]  = '{"ang_3245",  4'b1000, 16'h3245, 1'b0, 16'hCDBD, 1'b1, 1'b1};
        vecs[6]  = '{"sin_c000",  4'b0001, 16'hC000, 1'b0, 16'h2488, 1'b1, 1'b1};
        vecs[7]  = '{"cos_d000",  4'b0010, 16'hD000, 1'b0, 16'hD000, 1'b0, 1'b0};
        vecs[8]  = '{"func_0",    4'b0000, 16'h0100, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[9]  = '{"sin_pi",    4'b0001, 16'h6488, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[10] = '{"sin_pi_p1", 4'b0001, 16'h6489, 1'b1, 16'h0000, 1'b0, 1'b1};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_func  = 4'b0000;
        req_angle = 16'h0000;
        core_done = 1'b0;
        repeat (3) step();
        check("rst_ready",  req_ready, 1);
        check("rst_start",  core_start, 0);
        check("rst_x0",     core_x0, 0);
        check("rst_y0",     core_y0, 0);
        check("rst_z0",     core_z0, 0);
        check("rst_func",   core_func, 0);
        check("rst_neg",    core_neg, 0);
        check("rst_busy",   busy, 0);
        check("rst_err",    err_illegal, 0);
        rst = 1'b0;
        step();
        check("post_rst_ready", req_ready, 1);

        for (int i = 0; i < 11; i++) begin
            if (FOLD) single(vecs[i].tag, vecs[i].f, vecs[i].a, vecs[i].err_f, vecs[i].z_f, vecs[i].neg_f);
            else      single(vecs[i].tag, vecs[i].f, vecs[i].a, vecs[i].err_nf, vecs[i].a, 1'b0);
        end

        // Three back-to-back requests with the core stalled.
        base = n_issued;
        push_req(4'b0001, 16'h0100);
        push_req(4'b0010, 16'h0200);
        push_req(4'b0100, 16'h0300);
        check("b2b_ready_full", req_ready, 0);
        check("b2b_busy",       busy, 1);
        check("b2b_issued1",    n_issued - base, 1);
        check("b2b_z0_a",       issued_z0[base % 64], 16'h0100);
        pulse_done();
        step();
        step();
        check("b2b_issued2",    n_issued - base, 2);
        check("b2b_z0_b",       issued_z0[(base + 1) % 64], 16'h0200);
        check("b2b_ready_1",    req_ready, 1);
        pulse_done();
        step();
        step();
        check("b2b_issued3",    n_issued - base, 3);
        check("b2b_z0_c",       issued_z0[(base + 2) % 64], 16'h0300);
        check("b2b_func_c",     core_func, 4'b0100);
        pulse_done();
        check("b2b_idle_busy",  busy, 0);

        // Reset while waiting on the core with two entries still buffered.
        push_req(4'b0001, 16'h0400);
        push_req(4'b0001, 16'h0500);
        push_req(4'b0001, 16'h0600);
        check("mid_full",  req_ready, 0);
        check("mid_busy",  busy, 1);
        rst       = 1'b1;
        core_done = 1'b1;
        step();
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_start", core_start, 0);
        check("mid_rst_z0",    core_z0, 0);
        rst       = 1'b0;
        core_done = 1'b0;
        base = n_issued;
        repeat (5) step();
        check("mid_no_start", n_issued - base, 0);
        check("mid_idle_busy", busy, 0);

        single("after_rst", 4'b0010, 16'h0800, 1'b0, 16'h0800, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cordic_input_stage.md
CORDIC_INPUT_STAGE -- requirements
Module: cordic_input_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2: request buffer entries (power of two, >=2).
REQ-002 SHALL have parameter X_INIT, default 16'h2000: initial x (1.0, signed Q3.13).
REQ-003 SHALL have the following ports; one clock, reset synchronous and active-high:
 clk  in  1  clock, rising edge
 rst  in  1  synchronous active-high reset
 req_valid  in  1  request present
 req_ready  out  1  buffer can accept
 req_func  in  4  one-hot: [0] sin, [1] cos, [2] tan, [3] angle
 req_angle  in  16  signed Q3.13 radians
 core_start  out  1  one-cycle launch pulse to CORDIC core
 core_x0 / core_y0 / core_z0  out  16 each  initial x, y, z
 core_func  out  4  function select forwarded to output selection
 core_neg  out  1  result-negate flag (quadrant fold)
 core_done  in  1  core finished current operation
 busy  out  1  operation in flight or buffer non-empty
 err_illegal  out  1  one-cycle pulse: request rejected

Function
REQ-004 SHALL accept a request on a rising edge with req_valid && req_ready; req_ready = buffer not full.
REQ-005 SHALL reject, without buffering, any accepted request whose req_func is not one-hot or whose |req_angle| > PI (16'h6488), pulsing err_illegal the next cycle.
REQ-006 SHALL fold at acceptance: angle > PI_2 (16'h3244) -> z0 = angle - PI, neg = 1; angle < -PI_2 -> z0 = angle + PI, neg = 1; otherwise z0 = angle, neg = 0; arithmetic is 16-bit two's complement.
REQ-007 SHALL store {func, z0, neg} in a DEPTH-entry FIFO; simultaneous push and pop SHALL be allowed when full or empty, keeping order and count exact.
REQ-008 SHALL run an FSM with states IDLE, ISSUE, WAIT.
REQ-009 IDLE -> ISSUE when FIFO non-empty; ISSUE -> WAIT unconditionally; WAIT -> IDLE when core_done = 1.
REQ-010 In ISSUE, SHALL pop the FIFO head, assert core_start for exactly one cycle, and drive core_x0 = X_INIT, core_y0 = 0, core_z0/core_func/core_neg from the head.
REQ-011 core_x0/y0/z0/func/neg SHALL hold stable from ISSUE until the next ISSUE.
REQ-012 core_done SHALL be ignored outside WAIT.
REQ-013 Latency: acceptance in cycle N with idle FSM and empty FIFO -> core_start high in cycle N+2.
REQ-014 busy SHALL be 1 whenever state != IDLE or FIFO non-empty.

Reset
REQ-015 On rst, state = IDLE, FIFO flushed, req_ready = 1 the following cycle, core_start = 0, core_x0/y0/z0 = 0, core_func = 0, core_neg = 0, busy = 0, err_illegal = 0.
REQ-016 Reset mid-operation SHALL abandon the in-flight request without a further core_start; core_done during reset SHALL be ignored.

Configuration
REQ-017 With QUAD_FOLD_EN defined, folding per REQ-006 SHALL apply.
REQ-018 Without QUAD_FOLD_EN, z0 = req_angle, core_neg SHALL be tied to 0, and the REQ-005 range limit SHALL be PI_2 instead of PI.

Structure
REQ-019 Constants PI, PI_2, X_INIT default and one-hot function encodings SHALL reside in shared package cordic_pkg.
REQ-020 The FIFO SHALL be a sub-module cordic_req_fifo (parameter DEPTH, width 21); all other logic SHALL be in cordic_input_stage.

Verification
REQ-021 Sin, angle 16'h1000 -> core_start at N+2, z0 = 16'h1000, x0 = 16'h2000, y0 = 0, neg = 0, func = 4'b0001.
REQ-022 Cos, angle 16'h5000 (folding on) -> z0 = 16'hEB78, neg = 1; folding off -> rejected, err_illegal pulse.
REQ-023 req_func 4'b0011 or angle 16'h7000 -> no buffering, err_illegal high for one cycle, no core_start.
REQ-024 Three back-to-back requests, core_done held low -> req_ready drops after 2 buffered entries plus 1 issued; each core_done pulse releases the next core_start, issued in order.
REQ-025 rst asserted in WAIT with 2 buffered entries -> next cycle state IDLE, busy = 0, no core_start after reset release.
